led_blink_code_tx: RTL and testbench



---
 rtl/led_blink_code_tx_pkg.sv | 26 ++
 rtl/led_blink_code_tx_cycle_timer.sv | 28 ++
 rtl/led_blink_code_tx.sv | 130 +++++++++++++
 tb/tb_led_blink_code_tx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/led_blink_code_tx_pkg.sv
// Shared definitions for the LED blink-code user interface.
// Holds the sequencer state type, default timings and a helper that sizes timers.
package blink_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } blink_state_e;

    localparam int DEFAULT_CODE_W     = 4;
    localparam int DEFAULT_ON_CYCLES  = 3000000;
    localparam int DEFAULT_OFF_CYCLES = 3000000;
    localparam int DEFAULT_GAP_CYCLES = 12000000;

    // Bits needed for a down-counter that can hold the largest of three reload values.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/led_blink_code_tx_cycle_timer.sv
// Loadable down-counter that parks at zero and flags it.
// A load takes priority over counting; the zero flag comes straight from the register.
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_q;

    // Reload on request, otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/led_blink_code_tx.sv
// Blink-code transmitter: flashes an active-low LED N times, then holds a dark gap.
// A code is taken via valid/ready in IDLE only; done pulses for one cycle on return to IDLE.
module led_blink_code_tx
    import blink_pkg::*;
#(
    parameter int CODE_W     = DEFAULT_CODE_W,
    parameter int ON_CYCLES  = DEFAULT_ON_CYCLES,
    parameter int OFF_CYCLES = DEFAULT_OFF_CYCLES,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] code,
    input  logic              code_valid,
    output logic              code_ready,
    output logic              led_n,
    output logic              busy,
    output logic              done
);

    localparam int TIMER_W = timer_width(ON_CYCLES, OFF_CYCLES, GAP_CYCLES);

    localparam logic [TIMER_W-1:0] ON_RELOAD  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OFF_RELOAD = TIMER_W'(OFF_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_RELOAD = TIMER_W'(GAP_CYCLES - 1);

    blink_state_e        state_q, state_d;
    logic [CODE_W-1:0]   remaining_q, remaining_d;
    logic                led_q, led_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;

    logic                timer_load;
    logic [TIMER_W-1:0]  timer_val;
    logic                timer_zero;

    cycle_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    // Next-state, flash bookkeeping and timer reloads; outputs derive from the next state.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        timer_load  = 1'b0;
        timer_val   = '0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (code_valid && ready_q) begin
                    remaining_d = code;
                    timer_load  = 1'b1;
                    if (code != '0) begin
                        state_d   = ST_ON;
                        timer_val = ON_RELOAD;
                    end else begin
                        state_d   = ST_GAP;
                        timer_val = GAP_RELOAD;
                    end
                end
            end
            ST_ON: begin
                if (timer_zero) begin
                    remaining_d = remaining_q - 1'b1;
                    timer_load  = 1'b1;
                    if (remaining_q == CODE_W'(1)) begin
                        state_d   = ST_GAP;
                        timer_val = GAP_RELOAD;
                    end else begin
                        state_d   = ST_OFF;
                        timer_val = OFF_RELOAD;
                    end
                end
            end
            ST_OFF: begin
                if (timer_zero) begin
                    state_d    = ST_ON;
                    timer_load = 1'b1;
                    timer_val  = ON_RELOAD;
                end
            end
            ST_GAP: begin
                if (timer_zero) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        led_d   = (state_d != ST_ON);
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

    // Register state and every output so the LED pin never sees combinational glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            led_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            led_q       <= led_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
        end
    end

    assign led_n      = led_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign code_ready = ready_q;

endmodule

// File: tb/tb_led_blink_code_tx.sv
// Self-checking bench for led_blink_code_tx with short timings (ON=4, OFF=3, GAP=6).
// Expected waveforms are computed arithmetically from flash count and cycle offset.
module tb_led_blink_code_tx;

    localparam int CODE_W = 4;
    localparam int ON     = 4;
    localparam int OFF    = 3;
    localparam int GAP    = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CODE_W-1:0] code;
    logic              code_valid;
    logic              code_ready;
    logic              led_n;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    led_blink_code_tx #(
        .CODE_W     (CODE_W),
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .led_n      (led_n),
        .busy       (busy),
        .done       (done)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    // Cycle k of a sequence counts from the acceptance edge; done lands on this cycle.
    function automatic int doneCycle(input int n);
        if (n == 0) return 1 + GAP;
        return 1 + n * ON + (n - 1) * OFF + GAP;
    endfunction

    // LED is lit in the first ON cycles of each ON+OFF period, for the first n periods.
    function automatic logic expLed(input int n, input int k);
        int period;
        int phase;
        if (n == 0 || k < 1) return 1'b1;
        period = (k - 1) / (ON + OFF);
        phase  = (k - 1) % (ON + OFF);
        return !(period < n && phase < ON);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input int value);
        int v;
        v = value;
        code_valid = valid;
        code       = v[CODE_W-1:0];
    endtask

    // Called at a negedge in IDLE: offers a code that the next posedge accepts.
    task automatic startCode(input int n);
        checkOutput($sformatf("ready_before_code%0d", n), code_ready, 1);
        applyStimulus(1'b1, n);
    endtask

    // Walks cycles 1..done (or stopAt) of a sequence, checking every output each cycle.
    task automatic followCode(input int n, input int junkCycle, input int junkCode,
                              input bit holdValid, input int chainCode, input int stopAt);
        int   d;
        int   flashes;
        logic prevLed;
        d       = doneCycle(n);
        flashes = 0;
        prevLed = 1'b1;
        for (int k = 1; k <= d && k <= stopAt; k++) begin
            @(negedge clk);
            checkOutput($sformatf("led_n n=%0d k=%0d", n, k), led_n, expLed(n, k));
            checkOutput($sformatf("done n=%0d k=%0d", n, k), done, (k == d));
            checkOutput($sformatf("busy n=%0d k=%0d", n, k), busy, (k < d));
            checkOutput($sformatf("ready n=%0d k=%0d", n, k), code_ready, (k == d));
            if (prevLed && !led_n) flashes++;
            prevLed = led_n;
            if (k == d) begin
                if (chainCode >= 0) applyStimulus(1'b1, chainCode);
                else                applyStimulus(1'b0, 0);
            end else if (k == junkCycle) begin
                applyStimulus(1'b1, junkCode);
            end else if (holdValid) begin
                applyStimulus(1'b1, (chainCode >= 0) ? chainCode : junkCode);
            end else begin
                applyStimulus(1'b0, 0);
            end
        end
        if (stopAt >= d) checkOutput($sformatf("flash_count n=%0d", n), flashes, n);
    endtask

    initial begin
        int n;
        int d;
        int jc;
        int jcode;
        bit hold;

        rst_n = 1'b0;
        applyStimulus(1'b0, 0);

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_led_n", led_n, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_ready", code_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_release", code_ready, 1);
        checkOutput("busy_after_release", busy, 0);

        // Three flashes
        $display("[TB] code=3");
        startCode(3);
        followCode(3, 0, 0, 1'b0, -1, 1000);

        // Zero code: gap only
        $display("[TB] code=0");
        startCode(0);
        followCode(0, 0, 0, 1'b0, -1, 1000);

        // code_valid held high: code=1 then code=2 accepted in the done cycle
        $display("[TB] back-to-back 1 then 2");
        startCode(1);
        followCode(1, 0, 0, 1'b1, 2, 1000);
        followCode(2, 0, 0, 1'b0, -1, 1000);

        // code=5 with an ignored code=7 pulse mid-sequence
        $display("[TB] code=5 with ignored pulse");
        startCode(5);
        followCode(5, 6, 7, 1'b0, -1, 1000);

        // Reset while the second flash is lit
        $display("[TB] reset mid-sequence");
        startCode(3);
        followCode(3, 0, 0, 1'b0, -1, 9);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_led_n", led_n, 1);
        checkOutput("async_rst_busy", busy, 0);
        checkOutput("async_rst_done", done, 0);
        checkOutput("async_rst_ready", code_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("in_rst_done %0d", i), done, 0);
            checkOutput($sformatf("in_rst_led_n %0d", i), led_n, 1);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_rst2", code_ready, 1);
        startCode(1);
        followCode(1, 0, 0, 1'b0, -1, 1000);

        // Maximum code
        $display("[TB] code=15");
        startCode(15);
        followCode(15, 0, 0, 1'b0, -1, 1000);

        // Randomized codes, busy-time noise on code_valid
        $display("[TB] random sequences");
        for (int t = 0; t < 8; t++) begin
            n     = $urandom_range(0, (1 << CODE_W) - 1);
            d     = doneCycle(n);
            jc    = $urandom_range(1, d - 1);
            jcode = $urandom_range(0, (1 << CODE_W) - 1);
            hold  = 1'($urandom_range(0, 1));
            startCode(n);
            followCode(n, jc, jcode, hold, -1, 1000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
